// File: rtl/fetch_unit.sv
// ============================================================================
// Module   : fetch_unit
// Brief    : MIPS instruction-fetch stage. It owns the PC, handshakes with the
//            instruction memory, holds the fetched word and resolves branches
//            and jumps when the instruction retires.
//            Optional macro FETCH_PERF_EN adds the retire and taken counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit #(
    parameter int               ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [ADDR_W-1:0] pc,
    input  logic              branch,
    input  logic              jump,
    input  logic              alu_zero,
    input  logic              alu_neg,
    input  logic [31:0]       signimm,
    output logic [31:0]       instret,
    output logic [31:0]       br_taken_cnt
);

    typedef enum logic [0:0] {
        S_FETCH = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;

    logic              retire;
    logic              br_cond;
    logic              br_taken;
    logic [ADDR_W-1:0] pc4;
    logic [ADDR_W-1:0] br_target;
    logic [ADDR_W-1:0] jmp_target;
    logic [ADDR_W-1:0] next_pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign retire = (state_q == S_HOLD) & instr_ready;

    // Branch condition is decoded from the held opcode, not from decoder state.
    always_comb begin
        br_cond = 1'b0;
        case (instr_q[31:26])
            6'b000100: br_cond = alu_zero;
            6'b000101: br_cond = ~alu_zero;
            6'b000001: br_cond = alu_neg;
            6'b100110: br_cond = ~alu_neg;
            default:   br_cond = 1'b0;
        endcase
    end

    assign pc4        = pc_q + 32'd4;
    assign br_target  = pc4 + (signimm << 2);
    assign jmp_target = {pc4[31:28], instr_q[25:0], 2'b00};
    assign br_taken   = branch & br_cond;
    assign next_pc    = jump ? jmp_target : (br_taken ? br_target : pc4);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            S_FETCH: begin
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (retire) begin
                    pc_d    = next_pc;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Gating with reset keeps the request low for the whole reset pulse.
    assign imem_req    = (state_q == S_FETCH) & ~reset;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = (state_q == S_HOLD);
    assign pc          = pc_q;

`ifdef FETCH_PERF_EN
    logic [31:0] instret_q;
    logic [31:0] br_cnt_q;
    logic        redirect;

    assign redirect = jump | br_taken;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instret_q <= 32'h0;
            br_cnt_q  <= 32'h0;
        end else if (retire) begin
            instret_q <= instret_q + 32'd1;
            if (redirect) begin
                br_cnt_q <= br_cnt_q + 32'd1;
            end
        end
    end

    assign instret      = instret_q;
    assign br_taken_cnt = br_cnt_q;
`else
    assign instret      = 32'h0;
    assign br_taken_cnt = 32'h0;
`endif

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the main decoder in the single-cycle MIPS core.
- Owns the PC and runs a request/ready handshake to instruction memory, which may insert wait states.
- Holds the fetched word so the decoder and datapath can see its op field.
- On retirement, consumes the decoder's branch/jump controls plus ALU flags, resolves BEQ/BNE/BLT/BGE, and selects the next PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ADDR_W, 32, PC/address width; fixed at 32 for this core.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- imem_req  out  1  fetch request, held until accepted
- imem_addr  out  32  fetch address (= pc), stable while imem_req=1
- imem_ready  in  1  memory accepts request; imem_rdata is valid this same cycle
- imem_rdata  in  32  instruction word
- instr  out  32  held instruction; instr[31:26] drives the decoder op input
- instr_valid  out  1  instr holds a fetched, unretired instruction
- instr_ready  in  1  core retires instr this cycle
- pc  out  32  address of instr
- branch  in  1  decoder branch control
- jump  in  1  decoder jump control
- alu_zero  in  1  ALU result == 0
- alu_neg  in  1  ALU result sign bit (rs - rt)
- signimm  in  32  sign-extended immediate, in words
- instret  out  32  retired-instruction count (FETCH_PERF_EN)
- br_taken_cnt  out  32  taken branch/jump count (FETCH_PERF_EN)

Behaviour:
- States: FETCH, HOLD.
- Reset: asynchronous.
  - state=FETCH; pc=RESET_PC; instr=0; instr_valid=0; counters=0.
  - imem_req=0 while reset is high.
  - Reset asserted mid-request aborts the request: no retry, and the old address is not reissued.
- FETCH:
  - imem_req=1; imem_addr=pc; instr_valid=0.
  - When imem_ready=1: instr<=imem_rdata, go to HOLD.
  - When imem_ready=0: stay in FETCH with identical address.
  - Minimum fetch latency: 1 cycle (ready in the first request cycle).
- HOLD:
  - imem_req=0; instr_valid=1.
  - instr and pc are stable until retire.
- Retire (HOLD & instr_ready): pc<=next_pc, go to FETCH. Without instr_ready, stay in HOLD indefinitely.
- instr_ready outside HOLD is ignored.
- pc4 = pc + 4.
- Branch condition, decoded from instr[31:26]:
  - 000100 BEQ: alu_zero
  - 000101 BNE: ~alu_zero
  - 000001 BLT: alu_neg
  - 100110 BGE: ~alu_neg
  - Any other op with branch=1: not taken.
- next_pc priority:
  - jump=1: {pc4[31:28], instr[25:0], 2'b00}
  - else branch & cond: pc4 + (signimm << 2), modulo 2^32
  - else pc4
  - jump wins if jump and branch are both high.
- Wrap-around: pc 32'hFFFF_FFFC sequential → 32'h0000_0000. No flags.
- Branch offsets are computed as 32-bit two's-complement; carry-out is discarded.
- Controls and flags are sampled only in the retire cycle; X on them outside retire must not corrupt state.
- Fetch is never speculative: at most one outstanding request, and none while in HOLD.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - instret increments on each retire.
  - br_taken_cnt increments on retire when next_pc ≠ pc4 source (jump or taken branch).
  - Both are 32-bit wrapping counters, cleared by reset.
- Undefined: both ports are driven constant 0 and no counter flops exist.

Test Plan:
- Reset then sequential flow: RESET_PC=0, imem_ready=1, instr_ready=1 every HOLD → imem_addr sequence 0,4,8,C; instr_valid toggles 0/1 each cycle; first req one cycle after reset deassert.
- Wait states: imem_ready low for 3 cycles at addr 0x10 → imem_req and imem_addr=0x10 held 4 cycles; instr captured on the 4th; instr_valid rises the next cycle.
- Branches at pc=0x20, signimm=-2:
  - BEQ (op 000100), branch=1, zero=1 → next addr 0x1C.
  - Same with zero=0 → 0x24.
  - BNE/BLT/BGE, each checked taken and not taken.
- Jump priority: pc=0x4000_0000, instr[25:0]=0x0000100, jump=1 and branch=1 → next addr 0x4000_0400.
- Stall and reset abort:
  - instr_ready low 5 cycles in HOLD → no request, pc and instr stable.
  - Reset asserted during a pending fetch at 0x30 → imem_req drops immediately; after release, fetch restarts at RESET_PC.
- FETCH_PERF_EN defined: 10 retires including 3 taken branches and 1 jump → instret=10, br_taken_cnt=4. Undefined → both read 0.
